// File: rtl/scene_ctrl_if.sv
// Scene sequencer bus: game-logic inputs and the VGA-facing scene outputs.
interface scene_ctrl_if;
    logic       vsync;
    logic       start_btn;
    logic [2:0] p0_plate;
    logic [2:0] p1_plate;
    logic       p0_hazard;
    logic       p1_hazard;
    logic       p0_exit;
    logic       p1_exit;
    logic       p0_moving;
    logic       p1_moving;
    logic [3:0] state;
    logic [4:0] gate_open;
    logic       spike_on;
    logic [2:0] frame_idx;
    logic [2:0] frame_idx_1;
    logic       frame_tick;

    modport master (
        output vsync, start_btn, p0_plate, p1_plate, p0_hazard, p1_hazard,
               p0_exit, p1_exit, p0_moving, p1_moving,
        input  state, gate_open, spike_on, frame_idx, frame_idx_1, frame_tick
    );

    modport slave (
        input  vsync, start_btn, p0_plate, p1_plate, p0_hazard, p1_hazard,
               p0_exit, p1_exit, p0_moving, p1_moving,
        output state, gate_open, spike_on, frame_idx, frame_idx_1, frame_tick
    );
endinterface

// File: rtl/scene_ctrl.sv
// Frame-rate scene sequencer: game FSM, plate gates, spike duty cycle and
// per-player animation indices, all updated only on the vsync rising edge.
module scene_ctrl #(
    parameter int unsigned SPIKE_ON_FRAMES  = 60,
    parameter int unsigned SPIKE_OFF_FRAMES = 60,
    parameter int unsigned GATE_HOLD_FRAMES = 30,
    parameter int unsigned ANIM_DIV         = 8,
    parameter int unsigned END_HOLD_FRAMES  = 180
) (
    input  logic         clk,
    input  logic         rst,
    scene_ctrl_if.slave  bus
);
    localparam int unsigned CW = 8;
    localparam int unsigned NG = 3;
    localparam int unsigned NP = 2;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_LOSE  = 2'd2,
        ST_WIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            vsync_q;
    logic            tick;
    logic [2:0]      btn_q;
    logic            btn_rise;
    logic            start_pend_q, start_pend_d;
    logic            spike_on_q, spike_on_d;
    logic [CW-1:0]   spike_cnt_q, spike_cnt_d;
    logic [NG-1:0]   gate_q, gate_d;
    logic [CW-1:0]   gate_cnt_q [NG];
    logic [CW-1:0]   gate_cnt_d [NG];
    logic [CW-1:0]   end_cnt_q, end_cnt_d;
    logic [NP-1:0]   moving_q, moving_d;
    logic [CW-1:0]   div_q [NP];
    logic [CW-1:0]   div_d [NP];
    logic [2:0]      idx_q [NP];
    logic [2:0]      idx_d [NP];
    logic            frame_tick_q;

    logic [NG-1:0]   plate;
    logic [NP-1:0]   moving;

    assign tick     = bus.vsync & ~vsync_q;
    assign btn_rise = btn_q[1] & ~btn_q[2];
    assign plate    = bus.p0_plate | bus.p1_plate;
    assign moving   = {bus.p1_moving, bus.p0_moving};

    // State register plus button synchroniser and vsync edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_START;
            vsync_q      <= 1'b0;
            btn_q        <= '0;
            start_pend_q <= 1'b0;
            spike_on_q   <= 1'b0;
            spike_cnt_q  <= '0;
            gate_q       <= '0;
            end_cnt_q    <= '0;
            moving_q     <= '0;
            frame_tick_q <= 1'b0;
            for (int k = 0; k < int'(NG); k++) gate_cnt_q[k] <= '0;
            for (int p = 0; p < int'(NP); p++) begin
                div_q[p] <= '0;
                idx_q[p] <= '0;
            end
        end else begin
            state_q      <= state_d;
            vsync_q      <= bus.vsync;
            btn_q        <= {btn_q[1:0], bus.start_btn};
            start_pend_q <= start_pend_d;
            spike_on_q   <= spike_on_d;
            spike_cnt_q  <= spike_cnt_d;
            gate_q       <= gate_d;
            end_cnt_q    <= end_cnt_d;
            moving_q     <= moving_d;
            frame_tick_q <= tick;
            for (int k = 0; k < int'(NG); k++) gate_cnt_q[k] <= gate_cnt_d[k];
            for (int p = 0; p < int'(NP); p++) begin
                div_q[p] <= div_d[p];
                idx_q[p] <= idx_d[p];
            end
        end
    end

    // Next-state and scene datapath, evaluated only on a frame tick
    always_comb begin
        state_d      = state_q;
        start_pend_d = start_pend_q;
        spike_on_d   = spike_on_q;
        spike_cnt_d  = spike_cnt_q;
        gate_d       = gate_q;
        end_cnt_d    = end_cnt_q;
        moving_d     = moving_q;
        for (int k = 0; k < int'(NG); k++) gate_cnt_d[k] = gate_cnt_q[k];
        for (int p = 0; p < int'(NP); p++) begin
            div_d[p] = div_q[p];
            idx_d[p] = idx_q[p];
        end

        if (btn_rise) start_pend_d = 1'b1;

        if (tick) begin
            moving_d = moving;
            case (state_q)
                ST_START: begin
                    spike_on_d = 1'b0;
                    gate_d     = '0;
                    for (int p = 0; p < int'(NP); p++) idx_d[p] = '0;
                    if (start_pend_q) begin
                        state_d      = ST_PLAY;
                        start_pend_d = 1'b0;
                        spike_on_d   = 1'b1;
                        spike_cnt_d  = '0;
                        for (int k = 0; k < int'(NG); k++) gate_cnt_d[k] = '0;
                        for (int p = 0; p < int'(NP); p++) div_d[p] = '0;
                    end
                end

                ST_PLAY: begin
                    // Hazard checks the spike level shown during the frame just drawn
                    if ((bus.p0_hazard | bus.p1_hazard) & spike_on_q) begin
                        state_d   = ST_LOSE;
                        end_cnt_d = '0;
                    end else if (bus.p0_exit & bus.p1_exit) begin
                        state_d   = ST_WIN;
                        end_cnt_d = '0;
                    end

                    if (spike_on_q) begin
                        if (spike_cnt_q == CW'(SPIKE_ON_FRAMES - 1)) begin
                            spike_on_d  = 1'b0;
                            spike_cnt_d = '0;
                        end else begin
                            spike_cnt_d = spike_cnt_q + CW'(1);
                        end
                    end else begin
                        if (spike_cnt_q == CW'(SPIKE_OFF_FRAMES - 1)) begin
                            spike_on_d  = 1'b1;
                            spike_cnt_d = '0;
                        end else begin
                            spike_cnt_d = spike_cnt_q + CW'(1);
                        end
                    end

                    // A press reloads the hold and overrides a same-tick expiry
                    for (int k = 0; k < int'(NG); k++) begin
                        if (plate[k]) begin
                            gate_d[k]     = 1'b1;
                            gate_cnt_d[k] = CW'(GATE_HOLD_FRAMES);
                        end else if (gate_cnt_q[k] != '0) begin
                            gate_cnt_d[k] = gate_cnt_q[k] - CW'(1);
                            if (gate_cnt_q[k] == CW'(1)) gate_d[k] = 1'b0;
                        end
                    end

                    for (int p = 0; p < int'(NP); p++) begin
                        if (moving[p] != moving_q[p]) begin
                            idx_d[p] = '0;
                            div_d[p] = '0;
                        end else if (div_q[p] == CW'(ANIM_DIV - 1)) begin
                            div_d[p] = '0;
                            if (idx_q[p] >= (moving[p] ? 3'd5 : 3'd3)) idx_d[p] = '0;
                            else                                          idx_d[p] = idx_q[p] + 3'd1;
                        end else begin
                            div_d[p] = div_q[p] + CW'(1);
                        end
                    end
                end

                default: begin
                    start_pend_d = 1'b0;
                    spike_on_d   = 1'b0;
                    gate_d       = '0;
                    for (int p = 0; p < int'(NP); p++) idx_d[p] = '0;
                    if (end_cnt_q == CW'(END_HOLD_FRAMES - 1)) state_d = ST_START;
                    else                                        end_cnt_d = end_cnt_q + CW'(1);
                end
            endcase
        end
    end

    assign bus.state       = {2'b00, state_q};
    assign bus.gate_open   = {gate_q[0], gate_q[1], gate_q[2], 2'b00};
    assign bus.spike_on    = spike_on_q;
    assign bus.frame_idx   = idx_q[0];
    assign bus.frame_idx_1 = idx_q[1];
    assign bus.frame_tick  = frame_tick_q;
endmodule

// File: tb/tb_scene_ctrl.sv
// Randomized bench for scene_ctrl against a timestamp-based reference model.
module tb_scene_ctrl;
    logic clk;
    logic rst;

    scene_ctrl_if bus ();

    scene_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] pl0;
        logic [2:0] pl1;
        logic       hz0;
        logic       hz1;
        logic       ex0;
        logic       ex1;
        logic       mv0;
        logic       mv1;
    } fin_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: outputs derived from tick timestamps
    int       m_state;
    int       t_now;
    int       t_entry;
    int       end_start;
    int       last_press [3];
    int       seg_start  [2];
    bit       prev_mv    [2];
    bit       pend;
    bit       m_spike;
    bit [2:0] m_gate;
    int       m_idx      [2];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; t_now = 0; t_entry = 0; end_start = 0;
        pend = 1'b0; m_spike = 1'b0; m_gate = '0;
        for (int k = 0; k < 3; k++) last_press[k] = -1000;
        for (int p = 0; p < 2; p++) begin
            seg_start[p] = 0; prev_mv[p] = 1'b0; m_idx[p] = 0;
        end
    endtask

    task automatic model_tick(input fin_t f);
        bit mv [2];
        bit [2:0] pl;
        int nxt;
        mv[0] = f.mv0; mv[1] = f.mv1;
        pl = f.pl0 | f.pl1;
        t_now++;
        case (m_state)
            0: begin
                m_spike = 1'b0; m_gate = '0; m_idx[0] = 0; m_idx[1] = 0;
                if (pend) begin
                    pend = 1'b0; m_state = 1; t_entry = t_now; m_spike = 1'b1;
                    for (int k = 0; k < 3; k++) last_press[k] = -1000;
                    seg_start[0] = t_now; seg_start[1] = t_now;
                end
            end
            1: begin
                nxt = 1;
                if ((f.hz0 || f.hz1) && m_spike) nxt = 2;
                else if (f.ex0 && f.ex1)         nxt = 3;
                m_spike = (((t_now - t_entry) % 120) < 60);
                for (int k = 0; k < 3; k++) begin
                    if (pl[k]) last_press[k] = t_now;
                    m_gate[k] = ((t_now - last_press[k]) < 30);
                end
                for (int p = 0; p < 2; p++) begin
                    if (mv[p] != prev_mv[p]) seg_start[p] = t_now;
                    m_idx[p] = ((t_now - seg_start[p]) / 8) % (mv[p] ? 6 : 4);
                end
                if (nxt != 1) begin m_state = nxt; end_start = t_now; end
            end
            default: begin
                pend = 1'b0; m_spike = 1'b0; m_gate = '0; m_idx[0] = 0; m_idx[1] = 0;
                if (t_now - end_start == 180) m_state = 0;
            end
        endcase
        prev_mv[0] = mv[0]; prev_mv[1] = mv[1];
    endtask

    task automatic check_outputs(input string pfx);
        logic [4:0] exp_gate;
        exp_gate = {m_gate[0], m_gate[1], m_gate[2], 2'b00};
        check({pfx, "_state"}, 8'(bus.state),       8'(m_state));
        check({pfx, "_gate"},  8'(bus.gate_open),   8'(exp_gate));
        check({pfx, "_spike"}, 8'(bus.spike_on),    8'(m_spike));
        check({pfx, "_idx0"},  8'(bus.frame_idx),   8'(m_idx[0]));
        check({pfx, "_idx1"},  8'(bus.frame_idx_1), 8'(m_idx[1]));
    endtask

    // One frame: optional mid-frame button pulse, then a vsync rise with inputs f
    task automatic run_frame(input fin_t f, input bit press);
        int waited;
        @(negedge clk);
        if (press) begin
            bus.start_btn = 1'b1;
            repeat (2) @(negedge clk);
            bus.start_btn = 1'b0;
            pend = 1'b1;
        end
        repeat (4) @(negedge clk);
        check("hold_state", 8'(bus.state), 8'(m_state));
        bus.p0_plate = f.pl0;  bus.p1_plate = f.pl1;
        bus.p0_hazard = f.hz0; bus.p1_hazard = f.hz1;
        bus.p0_exit = f.ex0;   bus.p1_exit = f.ex1;
        bus.p0_moving = f.mv0; bus.p1_moving = f.mv1;
        bus.vsync = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.frame_tick && waited < 8);
        check("frame_tick", 8'(bus.frame_tick), 8'd1);
        model_tick(f);
        check_outputs("frm");
        @(negedge clk);
        check("tick_pulse", 8'(bus.frame_tick), 8'd0);
        bus.vsync = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst");
        check("rst_tick", 8'(bus.frame_tick), 8'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        fin_t f;
        fin_t z;
        int   guard;
        z = '0;
        rst = 1'b1;
        bus.vsync = 1'b0; bus.start_btn = 1'b0;
        bus.p0_plate = '0; bus.p1_plate = '0;
        bus.p0_hazard = 1'b0; bus.p1_hazard = 1'b0;
        bus.p0_exit = 1'b0; bus.p1_exit = 1'b0;
        bus.p0_moving = 1'b0; bus.p1_moving = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("por");
        check("por_tick", 8'(bus.frame_tick), 8'd0);
        rst = 1'b0;

        // Idle in START, then start request
        run_frame(z, 1'b0);
        run_frame(z, 1'b1);

        // Gate hold, expiry and re-press on the expiry tick
        f = z; f.pl1 = 3'b010;
        run_frame(f, 1'b0);
        repeat (30) run_frame(z, 1'b0);
        run_frame(f, 1'b0);
        repeat (29) run_frame(z, 1'b0);
        run_frame(f, 1'b0);
        repeat (32) run_frame(z, 1'b0);

        // Animation: walk past a wrap, go idle at index 4
        f = z; f.mv0 = 1'b1;
        guard = 0;
        do begin
            run_frame(f, 1'b0);
            guard++;
        end while (!(guard >= 48 && m_idx[0] == 4) && guard < 200);
        repeat (40) run_frame(z, 1'b0);

        // Hazard only while spikes are lowered: no LOSE
        for (int i = 0; i < 130; i++) begin
            f = z; f.hz0 = !m_spike;
            run_frame(f, 1'b0);
        end
        guard = 0;
        while (!m_spike && guard < 130) begin
            run_frame(z, 1'b0);
            guard++;
        end
        // Exit and hazard together with spikes raised: LOSE wins
        f = z; f.hz0 = 1'b1; f.ex0 = 1'b1; f.ex1 = 1'b1;
        run_frame(f, 1'b0);
        repeat (185) run_frame(z, 1'b0);

        // Randomized play with one mid-frame reset
        f = z;
        for (int i = 0; i < 700; i++) begin
            bit press;
            f.pl0 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            f.pl1 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            f.hz0 = ($urandom_range(0, 39) == 0);
            f.hz1 = ($urandom_range(0, 39) == 0);
            f.ex0 = ($urandom_range(0, 9) == 0);
            f.ex1 = f.ex0 ? ($urandom_range(0, 2) == 0) : 1'b0;
            if ($urandom_range(0, 9) == 0) f.mv0 = ~f.mv0;
            if ($urandom_range(0, 9) == 0) f.mv1 = ~f.mv1;
            press = (m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            run_frame(f, press);
            if (i == 300) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/scene_ctrl.md
# scene_ctrl

Frame-rate sequencer for the two-player game display path. Owns the scene state machine (START/PLAY/LOSE/WIN), the three plate-driven gates, the spike duty cycle and both characters' animation frame indices, and drives the `state`, `gate_open`, `spike_on`, `frame_idx` and `frame_idx_1` inputs of the VGA address generator. All visible changes happen only on a frame boundary (vsync rising edge), so a frame is never drawn with mixed scene data.

## Interface

Parameters:
- SPIKE_ON_FRAMES, default 60: frames spikes stay raised per cycle.
- SPIKE_OFF_FRAMES, default 60: frames spikes stay lowered per cycle.
- GATE_HOLD_FRAMES, default 30: frames a gate stays open after its plate is vacated.
- ANIM_DIV, default 8: frames per animation step.
- END_HOLD_FRAMES, default 180: frames LOSE/WIN are shown before returning to START.

Ports. Reset is `rst`, asynchronous and active-high; the clock is `clk`.
- clk, input, 1: 25 MHz pixel clock.
- rst, input, 1: asynchronous reset, active-high.
- vsync, input, 1: VGA vertical sync, synchronous to clk.
- start_btn, input, 1: raw start button, asynchronous level.
- p0_plate, input, 3: player 0 standing on plate 1/2/3 (bit 0 = plate 1).
- p1_plate, input, 3: player 1, same encoding.
- p0_hazard, input, 1: player 0 overlaps a spike tile.
- p1_hazard, input, 1: player 1 overlaps a spike tile.
- p0_exit, input, 1: player 0 overlaps an exit tile.
- p1_exit, input, 1: player 1 overlaps an exit tile.
- p0_moving, input, 1: player 0 walking.
- p1_moving, input, 1: player 1 walking.
- state, output, 4: 0 = START, 1 = PLAY, 2 = LOSE, 3 = WIN.
- gate_open, output, 5: [4] gate 1, [3] gate 2, [2] gate 3; [1:0] are always 0.
- spike_on, output, 1: spikes raised.
- frame_idx, output, 3: player 0 animation frame.
- frame_idx_1, output, 3: player 1 animation frame.
- frame_tick, output, 1: one-cycle pulse, high in the cycle where the updated values first appear.

## Operation

**Frame tick**
- `vsync` is registered into `vsync_q`.
- `tick = vsync & ~vsync_q`. Every update below happens only on a clk edge where `tick = 1`.

**Start request**
- `start_btn` passes through a 2-flop synchroniser followed by a rising-edge detector.
- Each edge sets `start_pend`.
- `start_pend` is cleared on a tick that consumes it, and also on any tick in LOSE or WIN.

**State machine (evaluated on tick)**
- START → PLAY when `start_pend` is set. On entry, clear all gate, spike and animation counters, set `spike_on = 1` and `gate_open = 0`.
- PLAY → LOSE when `(p0_hazard | p1_hazard) & spike_on`. This uses the `spike_on` value held before the tick.
- PLAY → WIN when `p0_exit & p1_exit`. If LOSE and WIN conditions occur on the same tick, LOSE wins.
- LOSE/WIN → START after END_HOLD_FRAMES ticks, counted from the entry tick. `start_btn` is ignored in these states.
- Outside PLAY, `gate_open`, `spike_on`, `frame_idx` and `frame_idx_1` are forced to 0 on the next tick.

**Spikes (PLAY only)**
- A phase counter counts ticks.
- While raised, `spike_on` drops after SPIKE_ON_FRAMES ticks. While lowered, it rises after SPIKE_OFF_FRAMES ticks. The counter reloads to 0 at each toggle.

**Gates (PLAY only; k = 1..3)**
- If `p0_plate[k-1] | p1_plate[k-1]` at a tick: the gate bit is set and its hold counter is loaded with GATE_HOLD_FRAMES.
- Otherwise, while the counter is non-zero: decrement it, and clear the bit when it reaches 0. The gate therefore closes on the GATE_HOLD_FRAMES-th tick after the plate is vacated.
- If a plate press and a counter expiry occur on the same tick, the reload wins and the gate stays open.

**Animation (PLAY only, per player)**
- A divider counts ticks 0..ANIM_DIV-1. At ANIM_DIV-1 the frame index advances.
- Moving: the index wraps 5 → 0 (6 frames). Idle: the index wraps 3 → 0 (4 frames).
- A change in `pN_moving` relative to its value at the previous tick resets that player's index and divider to 0 on that tick.
- Counter widths: 8 bits wide enough for each parameter; index arithmetic is 3-bit.

## Timing

- All outputs are registered.
- Reset values: state = 0, gate_open = 0, spike_on = 0, frame_idx = 0, frame_idx_1 = 0, frame_tick = 0. All internal counters, `start_pend` and the synchronisers also reset to 0.
- Reset asserted mid-frame takes effect immediately.
- Latency: vsync rises at edge N (sampled), so `tick = 1` during cycle N. The new outputs and `frame_tick = 1` are visible after edge N+1.
- Button-to-PLAY latency: 2 cycles of synchronisation plus edge detect, then the next tick.
- Inputs `pN_*` are sampled only on tick cycles.

## Test plan

- **Reset / start:** reset, then pulse `start_btn` mid-frame → state stays 0 until the next vsync rise, then becomes 1 with `spike_on = 1`, `gate_open = 0`, and `frame_tick` asserted in the same cycle.
- **Gate hold:** `p1_plate = 3'b010` for 1 tick, then 0 → `gate_open = 5'b01000` from that tick and clears on the 30th subsequent tick. Re-press on tick 30 → the gate stays open.
- **Spike duty cycle:** in PLAY with no inputs → `spike_on` alternates 60/60 ticks. `p0_hazard = 1` during an off phase gives no LOSE; during an on phase, state = 2 on that tick.
- **Simultaneous events:** `p0_exit = p1_exit = 1` together with a hazard while spikes are raised → state = 2. After 180 ticks → state = 0, and all other outputs are 0.
- **Animation:** `p0_moving = 1` → `frame_idx` steps 0..5 every 8 ticks and wraps to 0. Toggle to idle at index 4 → index 0 on that tick, then cycles 0..3.
